// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Receiving end of the game controller's score interface. Turns the
// controller's level strobes into single events, keeps a two-digit BCD score
// with saturation at both ends, and tracks a session high score that is
// latched whenever a game ends.
//
// Parameters
//   UP_STEP    BCD points added per scoreUp event      (00..99 BCD)
//   DOWN_STEP  BCD points removed per scoreDown event  (00..99 BCD)
//   MAX_SCORE  BCD saturation ceiling
//
// Ports
//   CLK           in   system clock
//   RST           in   asynchronous, active-low reset
//   scoreUp       in   fish-caught strobe (level, edge-detected here)
//   scoreDown     in   penalty strobe (level, edge-detected here)
//   scoreRst      in   new-game score clear (level, edge-detected here)
//   gameOver      in   end-of-game strobe (level, edge-detected here)
//   currentScore  out  BCD score, [7:4] tens, [3:0] ones
//   highScore     out  BCD session high score
//   newHigh       out  last gameOver produced a new record
//   scoreChanged  out  one-cycle pulse after currentScore changes value
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter logic [7:0] UP_STEP   = 8'h01,
  parameter logic [7:0] DOWN_STEP = 8'h01,
  parameter logic [7:0] MAX_SCORE = 8'h99
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scoreUp,
  input  logic       scoreDown,
  input  logic       scoreRst,
  input  logic       gameOver,
  output logic [7:0] currentScore,
  output logic [7:0] highScore,
  output logic       newHigh,
  output logic       scoreChanged
);

  // Bit positions of the four strobes inside the edge-detect vectors.
  localparam int EV_UP   = 0;
  localparam int EV_DOWN = 1;
  localparam int EV_RST  = 2;
  localparam int EV_GO   = 3;

  // Three-digit BCD difference with the final borrow out of the hundreds.
  typedef struct packed {
    logic        borrow;
    logic [11:0] value;
  } bcd3_diff_t;

  // ---------------------------------------------------------------------------
  // BCD helpers. Operands are assumed to hold valid BCD digits.
  // ---------------------------------------------------------------------------

  // Three-digit + two-digit BCD add with decimal carry between digits.
  function automatic logic [11:0] bcd3_add(input logic [11:0] a,
                                           input logic [7:0]  b);
    logic [4:0] d0;
    logic [4:0] d1;
    logic [3:0] d2;
    logic       c0;
    logic       c1;
    d0 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    c0 = (d0 > 5'd9);
    if (c0) d0 = d0 - 5'd10;
    d1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c0};
    c1 = (d1 > 5'd9);
    if (c1) d1 = d1 - 5'd10;
    d2 = a[11:8] + {3'b0, c1};
    return {d2, d1[3:0], d0[3:0]};
  endfunction

  // Three-digit - two-digit BCD subtract with decimal borrow. A negative
  // digit shows up as bit 4 set in the 5-bit working value; adding ten
  // (mod 32) brings it back into 0..9.
  function automatic bcd3_diff_t bcd3_sub(input logic [11:0] a,
                                          input logic [7:0]  b);
    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] d2;
    logic       br0;
    logic       br1;
    bcd3_diff_t r;
    d0  = {1'b0, a[3:0]} - {1'b0, b[3:0]};
    br0 = d0[4];
    if (br0) d0 = d0 + 5'd10;
    d1  = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'b0, br0};
    br1 = d1[4];
    if (br1) d1 = d1 + 5'd10;
    d2  = {1'b0, a[11:8]} - {4'b0, br1};
    r.borrow = d2[4];
    r.value  = {d2[3:0], d1[3:0], d0[3:0]};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  // prev_q holds last cycle's level. armed_q records that the strobe has been
  // seen low at least once since reset, so a level already high when reset is
  // released is not mistaken for a fresh rising edge.
  logic [3:0] strobe_raw;
  logic [3:0] prev_q;
  logic [3:0] armed_q;
  logic [3:0] event_w;

  assign strobe_raw = {gameOver, scoreRst, scoreDown, scoreUp};
  assign event_w    = strobe_raw & ~prev_q & armed_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q  <= '0;
      armed_q <= '0;
    end else begin
      prev_q  <= strobe_raw;
      armed_q <= armed_q | ~strobe_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // Score arithmetic
  // ---------------------------------------------------------------------------
  // The add is done first into a three-digit intermediate so that a
  // simultaneous up/down pair saturates only on the net result (99+1-1 = 99,
  // not min(100,99)-1 = 98).
  logic [7:0]  score_q;
  logic [7:0]  score_d;
  logic [7:0]  high_q;
  logic [7:0]  high_d;
  logic        new_high_q;
  logic        new_high_d;
  logic        changed_q;
  logic        changed_d;

  logic [7:0]  up_amount;
  logic [7:0]  down_amount;
  logic [11:0] sum3;
  bcd3_diff_t  net3;
  logic [7:0]  arith_score;

  assign up_amount   = event_w[EV_UP]   ? UP_STEP   : 8'h00;
  assign down_amount = event_w[EV_DOWN] ? DOWN_STEP : 8'h00;
  assign sum3        = bcd3_add({4'h0, score_q}, up_amount);
  assign net3        = bcd3_sub(sum3, down_amount);

  // Clamp below at 00 (borrow out) and above at MAX_SCORE (hundreds digit
  // set, or two-digit value past the ceiling). Valid BCD compares correctly
  // as plain binary.
  always_comb begin
    if (net3.borrow) begin
      arith_score = 8'h00;
    end else if ((net3.value[11:8] != 4'h0) || (net3.value[7:0] > MAX_SCORE)) begin
      arith_score = MAX_SCORE;
    end else begin
      arith_score = net3.value[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: scoreRst beats gameOver beats up/down arithmetic.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;

    if (event_w[EV_RST]) begin
      score_d    = 8'h00;
      new_high_d = 1'b0;
    end else if (event_w[EV_GO]) begin
      if (score_q > high_q) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end else begin
        new_high_d = 1'b0;
      end
    end else if (event_w[EV_UP] || event_w[EV_DOWN]) begin
      score_d = arith_score;
    end

    // Covers every case uniformly: a clear of a zero score, saturated
    // no-ops and a net-zero up/down pair all leave the value unchanged.
    changed_d = (score_d != score_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      score_q    <= 8'h00;
      high_q     <= 8'h00;
      new_high_q <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      changed_q  <= changed_d;
    end
  end

  assign currentScore = score_q;
  assign highScore    = high_q;
  assign newHigh      = new_high_q;
  assign scoreChanged = changed_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//
// Drives two score_keeper instances from the same strobes: dut_a with the
// default steps (+1/-1) and dut_b with UP_STEP=05, DOWN_STEP=02. A decimal
// reference model (plain integers 0..99, clamped arithmetic) follows both.
// Directed scenarios compare against literal expected values; a randomized
// run compares every output of both instances against the model each cycle.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  logic       CLK;
  logic       RST;
  logic       scoreUp;
  logic       scoreDown;
  logic       scoreRst;
  logic       gameOver;
  logic [7:0] cur_a, high_a, cur_b, high_b;
  logic       nh_a, chg_a, nh_b, chg_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int score;
    int high;
    bit nh;
    bit chg;
  } model_t;

  model_t ma;
  model_t mb;
  bit     m_prev[4];
  bit     m_seen[4];

  score_keeper dut_a (
    .CLK(CLK), .RST(RST),
    .scoreUp(scoreUp), .scoreDown(scoreDown),
    .scoreRst(scoreRst), .gameOver(gameOver),
    .currentScore(cur_a), .highScore(high_a),
    .newHigh(nh_a), .scoreChanged(chg_a)
  );

  score_keeper #(.UP_STEP(8'h05), .DOWN_STEP(8'h02), .MAX_SCORE(8'h99)) dut_b (
    .CLK(CLK), .RST(RST),
    .scoreUp(scoreUp), .scoreDown(scoreDown),
    .scoreRst(scoreRst), .gameOver(gameOver),
    .currentScore(cur_b), .highScore(high_b),
    .newHigh(nh_b), .scoreChanged(chg_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic model_t apply(input model_t m, input bit up, input bit dn,
                                   input bit rs, input bit go,
                                   input int us, input int ds);
    model_t n = m;
    int     v;
    if (rs) begin
      n.score = 0;
      n.nh    = 1'b0;
    end else if (go) begin
      if (m.score > m.high) begin
        n.high = m.score;
        n.nh   = 1'b1;
      end else begin
        n.nh = 1'b0;
      end
    end else if (up || dn) begin
      v = m.score + (up ? us : 0) - (dn ? ds : 0);
      if (v < 0)  v = 0;
      if (v > 99) v = 99;
      n.score = v;
    end
    n.chg = (n.score != m.score);
    return n;
  endfunction

  function automatic void model_reset();
    ma = '{0, 0, 1'b0, 1'b0};
    mb = '{0, 0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 1'b0;
      m_seen[i] = 1'b0;
    end
  endfunction

  // One clock: drive levels at the falling edge, let the rising edge sample
  // them, advance the model, return at the next falling edge for sampling.
  task automatic step(input bit u, input bit d, input bit r, input bit g);
    bit lv[4];
    bit ev[4];
    scoreUp   = u;
    scoreDown = d;
    scoreRst  = r;
    gameOver  = g;
    lv = '{u, d, r, g};
    @(posedge CLK);
    for (int i = 0; i < 4; i++) begin
      ev[i] = lv[i] && !m_prev[i] && m_seen[i];
      if (!lv[i]) m_seen[i] = 1'b1;
      m_prev[i] = lv[i];
    end
    ma = apply(ma, ev[0], ev[1], ev[2], ev[3], 1, 1);
    mb = apply(mb, ev[0], ev[1], ev[2], ev[3], 5, 2);
    @(negedge CLK);
  endtask

  task automatic pulse(input bit u, input bit d, input bit r, input bit g);
    step(u, d, r, g);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Walk dut_a's score to a target using single-point pulses.
  task automatic go_to(input int target);
    int guard = 0;
    while (ma.score != target && guard < 300) begin
      if (ma.score < target) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      else                   pulse(1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      failures++;
      $display("FAIL go_to_budget: target %0d not reached, model at %0d", target, ma.score);
    end
  endtask

  // Walk dut_b's score (+5 / -2 steps) to a target.
  task automatic go_to_b(input int target);
    int guard = 0;
    while (mb.score != target && guard < 300) begin
      if (mb.score < target) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      else                   pulse(1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      failures++;
      $display("FAIL go_to_b_budget: target %0d not reached, model at %0d", target, mb.score);
    end
  endtask

  task automatic do_reset();
    scoreUp = 1'b0; scoreDown = 1'b0; scoreRst = 1'b0; gameOver = 1'b0;
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    scoreUp = 1'b0; scoreDown = 1'b0; scoreRst = 1'b0; gameOver = 1'b0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    checks++;
    if ({cur_a, high_a, nh_a, chg_a} !== 18'h0) begin
      failures++;
      $display("FAIL reset_a: got %h/%h/%b/%b want 00/00/0/0", cur_a, high_a, nh_a, chg_a);
    end
    checks++;
    if ({cur_b, high_b, nh_b, chg_b} !== 18'h0) begin
      failures++;
      $display("FAIL reset_b: got %h/%h/%b/%b want 00/00/0/0", cur_b, high_b, nh_b, chg_b);
    end
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({cur_a, high_a, nh_a, chg_a} !== 18'h0) begin
      failures++;
      $display("FAIL reset_release: got %h/%h/%b/%b want 00/00/0/0", cur_a, high_a, nh_a, chg_a);
    end
  endtask

  task automatic test_up_sequence();
    int pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cur_a !== bcd(k)) begin
        failures++;
        $display("FAIL up_seq_score[%0d]: got %h want %h", k, cur_a, bcd(k));
      end
      if (chg_a === 1'b1) pulses++;
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (chg_a === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 12) begin
      failures++;
      $display("FAIL up_seq_changed_count: got %0d want 12", pulses);
    end
  endtask

  task automatic test_saturation();
    go_to(98);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cur_a !== 8'h99 || chg_a !== (i == 0)) begin
        failures++;
        $display("FAIL sat_high[%0d]: got %h chg=%b want 99 chg=%b", i, cur_a, chg_a, (i == 0));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    go_to(1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (cur_a !== 8'h00 || chg_a !== (i == 0)) begin
        failures++;
        $display("FAIL sat_low[%0d]: got %h chg=%b want 00 chg=%b", i, cur_a, chg_a, (i == 0));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_held_level();
    int changes = 0;
    int s0 = ma.score;
    repeat (20) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (chg_a === 1'b1) changes++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cur_a !== bcd(s0 + 1) || changes != 1) begin
      failures++;
      $display("FAIL held_level: got %h changes=%0d want %h changes=1", cur_a, changes, bcd(s0 + 1));
    end
  endtask

  task automatic test_simultaneous();
    go_to(42);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cur_a !== 8'h42 || chg_a !== 1'b0) begin
      failures++;
      $display("FAIL up_down_net_zero: got %h chg=%b want 42 chg=0", cur_a, chg_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_step_params();
    go_to_b(97);
    checks++;
    if (cur_b !== 8'h97) begin
      failures++;
      $display("FAIL steps_setup: got %h want 97", cur_b);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cur_b !== 8'h99 || chg_b !== 1'b1) begin
      failures++;
      $display("FAIL steps_net_saturate: got %h chg=%b want 99 chg=1", cur_b, chg_b);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_game_over();
    go_to(15);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (high_a !== 8'h15 || nh_a !== 1'b1 || cur_a !== 8'h15 || chg_a !== 1'b0) begin
      failures++;
      $display("FAIL go_record: got hi=%h nh=%b cur=%h chg=%b want 15/1/15/0", high_a, nh_a, cur_a, chg_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cur_a !== 8'h00 || nh_a !== 1'b0 || high_a !== 8'h15 || chg_a !== 1'b1) begin
      failures++;
      $display("FAIL score_rst: got cur=%h nh=%b hi=%h chg=%b want 00/0/15/1", cur_a, nh_a, high_a, chg_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (high_a !== 8'h15 || nh_a !== 1'b0) begin
      failures++;
      $display("FAIL go_no_record: got hi=%h nh=%b want 15/0", high_a, nh_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    go_to(30);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cur_a !== 8'h00 || chg_a !== 1'b1) begin
      failures++;
      $display("FAIL rst_beats_up: got %h chg=%b want 00 chg=1", cur_a, chg_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(10);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (high_a !== 8'h10) begin
      failures++;
      $display("FAIL prio_setup_high: got %h want 10", high_a);
    end
    go_to(20);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (high_a !== 8'h20 || nh_a !== 1'b1 || cur_a !== 8'h20) begin
      failures++;
      $display("FAIL go_beats_up: got hi=%h nh=%b cur=%h want 20/1/20", high_a, nh_a, cur_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    go_to(60);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    go_to(55);
    checks++;
    if (cur_a !== 8'h55 || high_a !== 8'h60 || nh_a !== 1'b1) begin
      failures++;
      $display("FAIL async_setup: got cur=%h hi=%h nh=%b want 55/60/1", cur_a, high_a, nh_a);
    end
    // Mid low-phase, away from any rising edge, with an up event pending.
    #2;
    scoreUp = 1'b1;
    RST     = 1'b0;
    #1;
    checks++;
    if ({cur_a, high_a, nh_a, chg_a} !== 18'h0) begin
      failures++;
      $display("FAIL async_reset: got %h/%h/%b/%b want 00/00/0/0", cur_a, high_a, nh_a, chg_a);
    end
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cur_a !== 8'h00 || chg_a !== 1'b0) begin
        failures++;
        $display("FAIL held_across_reset[%0d]: got %h chg=%b want 00 chg=0", i, cur_a, chg_a);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cur_a !== 8'h01 || chg_a !== 1'b1) begin
      failures++;
      $display("FAIL first_edge_after_low: got %h chg=%b want 01 chg=1", cur_a, chg_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit u, d, r, g;
    for (int n = 0; n < 400; n++) begin
      u = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 39) == 0);
      g = ($urandom_range(0, 19) == 0);
      step(u, d, r, g);
      checks++;
      if (cur_a !== bcd(ma.score) || high_a !== bcd(ma.high) || nh_a !== ma.nh || chg_a !== ma.chg) begin
        failures++;
        $display("FAIL random_a[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", n,
                 cur_a, high_a, nh_a, chg_a, bcd(ma.score), bcd(ma.high), ma.nh, ma.chg);
      end
      checks++;
      if (cur_b !== bcd(mb.score) || high_b !== bcd(mb.high) || nh_b !== mb.nh || chg_b !== mb.chg) begin
        failures++;
        $display("FAIL random_b[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", n,
                 cur_b, high_b, nh_b, chg_b, bcd(mb.score), bcd(mb.high), mb.nh, mb.chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_saturation();
    test_held_level();
    test_simultaneous();
    test_step_params();
    test_game_over();
    test_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Receiving end of the game controller's score interface.
- Consumes the controller's scoreUp / scoreDown / scoreRst strobes and maintains the two-digit BCD score (currentScore) that feeds back into the controller's difficulty logic and the 7-segment drivers.
- Also keeps a session high score, latched on game-over, with a new-record flag for the display.

Parameters:
- UP_STEP, 8'h01, BCD points added per scoreUp event (valid 00..99 BCD)
- DOWN_STEP, 8'h01, BCD points removed per scoreDown event (valid 00..99 BCD)
- MAX_SCORE, 8'h99, BCD saturation ceiling

Ports:
- CLK  in  1  system clock (10 kHz in the game build)
- RST  in  1  asynchronous, active-low reset
- scoreUp  in  1  fish-caught strobe from controller (level; edge-detected here)
- scoreDown  in  1  boot/penalty strobe from controller (level; edge-detected)
- scoreRst  in  1  new-game score clear (level; edge-detected)
- gameOver  in  1  end-of-game strobe (level; edge-detected)
- currentScore  out  8  BCD score, [7:4] tens, [3:0] ones
- highScore  out  8  BCD session high score
- newHigh  out  1  set when the last gameOver produced a new record
- scoreChanged  out  1  one-cycle pulse whenever currentScore changes value

Behaviour:
- Reset (RST=0, async): currentScore=8'h00, highScore=8'h00, newHigh=0, scoreChanged=0, all edge-detect registers=0. On release, the first edge is detected only after an input has been seen low for one clock.
- Edge detect: each input is registered once (prev_x). An event fires when x=1 && prev_x=0 at a rising CLK edge. A held level counts once. The result is visible after that same edge (1-cycle latency from input assertion sampled at an edge).
- Priority per cycle: scoreRst event > gameOver event > up/down arithmetic.
- scoreRst event: currentScore<=00, newHigh<=0. highScore is kept. scoreChanged=1 only if the old score was nonzero. Any simultaneous up/down/gameOver events are ignored.
- gameOver event: if currentScore > highScore (BCD compare = binary compare on valid BCD), then highScore<=currentScore and newHigh<=1. Otherwise newHigh<=0. currentScore is unchanged. Simultaneous up/down events are ignored.
- Up only: currentScore <= min(currentScore + UP_STEP, MAX_SCORE) using digit-wise BCD add with decimal carry (ones >9 -> subtract 10, carry to tens). Tens overflow saturates to MAX_SCORE.
- Down only: currentScore <= max(currentScore - DOWN_STEP, 00) using BCD subtract with decimal borrow. Underflow clamps to 00, with no wrap.
- Up and down same cycle: apply the net, i.e. add UP_STEP then subtract DOWN_STEP, with saturation only on the final result (e.g. 99 +1 -1 = 99 requires the intermediate value to be computed as 100, so use a 9-bit/3-digit intermediate).
- scoreChanged: registered. 1 for exactly one cycle after any edge where currentScore's new value differs from its old value, else 0. Saturated no-ops (up at 99, down at 00) give scoreChanged=0.
- Outputs are always valid BCD. Digits never exceed 9.
- No FSM beyond the event logic. All state lives in score/high/flag/edge registers. Async reset mid-event discards the event.

Test Plan:
- Reset, then 12 scoreUp pulses (1 cycle high, 3 low) -> currentScore steps 01..09,10,11,12 with BCD carry at 09->10. scoreChanged pulses 12 times.
- From 98: 3 scoreUp pulses -> 99, 99, 99. scoreChanged only on the first. From 01: 2 scoreDown -> 00, 00.
- scoreUp held high 20 cycles -> exactly one increment. scoreUp and scoreDown rising the same edge at 42 -> stays 42, scoreChanged=0. With UP_STEP=8'h05 and DOWN_STEP=8'h02: 97 with both -> 99 (not clamped at the intermediate stage).
- Score 15, gameOver -> highScore=15, newHigh=1. scoreRst -> currentScore=00, newHigh=0, highScore=15. Score 07, gameOver -> highScore stays 15, newHigh=0.
- scoreRst and scoreUp rising the same edge at 30 -> 00. gameOver and scoreUp the same edge at 20 with highScore=10 -> highScore=20, currentScore stays 20.
- Assert RST low mid-run at score 55, highScore 60 -> all outputs 0 immediately, without waiting for CLK. Input held high across reset release -> no event until it toggles low then high.
